// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared helpers for the pipelined mux tree.
//   - sel_width()          : number of select bits needed for an N:1 tree
//   - is_pow2()            : power-of-two test used by the elaboration checks
//   - default_stage_mask() : stock register placements for the two known users
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [0:0] {
        USE_ALU = 1'b0,   // ALU result select: register the final level
        USE_FWD = 1'b1    // forwarding select: fully combinational
    } mux_use_e;

    localparam logic [2:0] ALU_STAGE_MASK = 3'b100;
    localparam logic [1:0] FWD_STAGE_MASK = 2'b00;

    function automatic int unsigned sel_width(input int unsigned n);
        for (int unsigned w = 0; w < 32; w++) begin
            if ((64'd1 << w) >= 64'(n)) return w;
        end
        return 32;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic int unsigned default_stage_mask(input mux_use_e use_case);
        return (use_case == USE_FWD) ? 32'(FWD_STAGE_MASK) : 32'(ALU_STAGE_MASK);
    endfunction

endpackage

// File: rtl/mux_level.sv
// -----------------------------------------------------------------------------
// mux_level
//   One level of the select tree: IN_CNT/2 pairwise 2:1 muxes steered by
//   sel[0]. The select bits not consumed here (sel[SEL_REM-1:1]) and the valid
//   bit travel with the data. With REG=1 data, select and valid are registered.
//
//   Ports
//     clk, reset      rising-edge clock, synchronous active-low reset
//     en              advance enable (0 holds all registers)
//     flush           clears the valid register; data still follows en
//     in_valid, inp   request entering this level (IN_CNT entries of WIDTH)
//     sel             remaining select; bit 0 belongs to this level
//     out_valid, out  request leaving this level (IN_CNT/2 entries)
//     sel_out         select bits for the following levels (0 on the last)
// -----------------------------------------------------------------------------
module mux_level
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH   = 64,
    parameter  int unsigned IN_CNT  = 8,
    parameter  int unsigned REG     = 0,
    parameter  int unsigned SEL_REM = 3,
    localparam int unsigned OUT_CNT = IN_CNT / 2,
    localparam int unsigned SO_W    = (SEL_REM > 1) ? SEL_REM - 1 : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [IN_CNT*WIDTH-1:0]   inp,
    input  logic [SEL_REM-1:0]        sel,
    output logic                      out_valid,
    output logic [OUT_CNT*WIDTH-1:0]  out,
    output logic [SO_W-1:0]           sel_out
);

    logic [OUT_CNT*WIDTH-1:0] mux_d;
    logic [SO_W-1:0]          sel_rest;

    // NOTE: assigning a default before the loop guarantees every bit is
    // written on every pass, so no latch can be inferred.
    always_comb begin
        mux_d = '0;
        for (int unsigned i = 0; i < OUT_CNT; i++) begin
            mux_d[i*WIDTH +: WIDTH] = sel[0] ? inp[(2*i+1)*WIDTH +: WIDTH]
                                             : inp[(2*i)*WIDTH +: WIDTH];
        end
    end

    if (SEL_REM > 1) begin : g_rest
        assign sel_rest = sel[SEL_REM-1:1];
    end else begin : g_last
        assign sel_rest = '0;
    end

    if (REG != 0) begin : g_reg
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            // NOTE: data and select registers are reset along with valid so
            // out reads 0 after reset rather than stale in-flight data.
            if (!reset) begin
                out       <= '0;
                sel_out   <= '0;
                out_valid <= 1'b0;
            end else begin
                if (en) begin
                    out     <= mux_d;
                    sel_out <= sel_rest;
                end
                // Flush outranks en for valid only; data keeps following en.
                if (flush) begin
                    out_valid <= 1'b0;
                end else if (en) begin
                    out_valid <= in_valid;
                end
            end
        end
    end else begin : g_comb
        logic ctl_unused;
        assign ctl_unused = ^{clk, reset, en, flush};
        assign out        = mux_d;
        assign sel_out    = sel_rest;
        assign out_valid  = in_valid;
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
//   N:1 selector of WIDTH-bit inputs built as log2(N) chained mux_level
//   instances. STAGE_MASK bit k registers the output of level k (level 0 is
//   nearest the inputs); latency is popcount(STAGE_MASK) enabled cycles.
//
//   Ports
//     clk, reset       rising-edge clock, synchronous active-low reset
//     en               advance enable; 0 stalls every pipeline register
//     flush            drops all in-flight valid bits (and this cycle's request)
//     in_valid         inp/sel carry a request this cycle
//     inp              flattened inputs, input i = inp[i*WIDTH +: WIDTH]
//     sel              index of the input to pass
//     out_valid, out   selected data and its valid bit
// -----------------------------------------------------------------------------
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH      = 64,
    parameter  int unsigned N          = 8,
    parameter  int unsigned STAGE_MASK = default_stage_mask(USE_ALU),
    localparam int unsigned SEL_W      = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [N*WIDTH-1:0]   inp,
    input  logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out
);

    if (!is_pow2(N) || N < 2) begin : g_chk_n
        $fatal(1, "mux_tree_pipe: N must be a power of two and at least 2");
    end
    if ((STAGE_MASK >> SEL_W) != 0) begin : g_chk_mask
        $fatal(1, "mux_tree_pipe: STAGE_MASK is wider than log2(N)");
    end

    // All tree nodes live in one flat bus: the N inputs first, then the N/2
    // outputs of level 0, then N/4 of level 1, ... ending with the single root.
    // The select bus is laid out the same way, shrinking by one bit per level.
    localparam int unsigned SBUS_W = SEL_W * (SEL_W + 1) / 2 + 1;

    logic [(2*N-1)*WIDTH-1:0] tree;
    logic [SBUS_W-1:0]        sbus;
    logic [SEL_W:0]           vld;
    logic                     sel_tail_unused;

    assign tree[N*WIDTH-1:0] = inp;
    assign sbus[SEL_W-1:0]   = sel;
    assign vld[0]            = in_valid;

    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int unsigned IN_CNT  = N >> k;
        localparam int unsigned SEL_REM = SEL_W - k;
        localparam int unsigned DI      = 2 * N - 2 * IN_CNT;   // first input node
        localparam int unsigned DO      = DI + IN_CNT;          // first output node
        localparam int unsigned SI      = k * SEL_W - (k * (k - 1)) / 2;
        localparam int unsigned SO      = SI + SEL_REM;
        localparam int unsigned SO_W    = (SEL_REM > 1) ? SEL_REM - 1 : 1;

        mux_level #(
            .WIDTH   (WIDTH),
            .IN_CNT  (IN_CNT),
            .REG     ((STAGE_MASK >> k) & 1),
            .SEL_REM (SEL_REM)
        ) u_level (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .flush     (flush),
            .in_valid  (vld[k]),
            .inp       (tree[DI*WIDTH +: IN_CNT*WIDTH]),
            .sel       (sbus[SI +: SEL_REM]),
            .out_valid (vld[k+1]),
            .out       (tree[DO*WIDTH +: (IN_CNT/2)*WIDTH]),
            .sel_out   (sbus[SO +: SO_W])
        );
    end

    // The last level has no select left to forward; its spare constant bit ends here.
    assign sel_tail_unused = sbus[SBUS_W-1];

    assign out       = tree[(2*N-2)*WIDTH +: WIDTH];
    assign out_valid = vld[SEL_W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
//   Four instances share one clock and reset:
//     u0 : N=8,  WIDTH=64, STAGE_MASK=3'b000 (L=0, combinational)
//     u1 : N=8,  WIDTH=64, STAGE_MASK=3'b101 (L=2)
//     u2 : N=8,  WIDTH=64, STAGE_MASK=3'b111 (L=3)
//     u3 : N=32, WIDTH=8,  STAGE_MASK=5'b01010 (L=2)
//   u0..u2 share one stimulus set, u3 has its own. The reference model is a
//   delay line of L slots per instance holding {valid, input[sel]} per request.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;

    localparam int NM = 4;

    logic clk = 1'b0;
    logic reset;

    logic         en8, fl8, iv8;
    logic [511:0] inp8;
    logic [2:0]   sel8;
    logic         en32, fl32, iv32;
    logic [255:0] inp32;
    logic [4:0]   sel32;

    logic        ov0, ov1, ov2, ov3;
    logic [63:0] o0, o1, o2;
    logic [7:0]  o3;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.WIDTH(64), .N(8), .STAGE_MASK(3'b000)) u0 (
        .clk(clk), .reset(reset), .en(en8), .flush(fl8), .in_valid(iv8),
        .inp(inp8), .sel(sel8), .out_valid(ov0), .out(o0));
    mux_tree_pipe #(.WIDTH(64), .N(8), .STAGE_MASK(3'b101)) u1 (
        .clk(clk), .reset(reset), .en(en8), .flush(fl8), .in_valid(iv8),
        .inp(inp8), .sel(sel8), .out_valid(ov1), .out(o1));
    mux_tree_pipe #(.WIDTH(64), .N(8), .STAGE_MASK(3'b111)) u2 (
        .clk(clk), .reset(reset), .en(en8), .flush(fl8), .in_valid(iv8),
        .inp(inp8), .sel(sel8), .out_valid(ov2), .out(o2));
    mux_tree_pipe #(.WIDTH(8), .N(32), .STAGE_MASK(5'b01010)) u3 (
        .clk(clk), .reset(reset), .en(en32), .flush(fl32), .in_valid(iv32),
        .inp(inp32), .sel(sel32), .out_valid(ov3), .out(o3));

    function automatic int lat_of(input int k);
        case (k)
            1:       return 2;
            2:       return 3;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What each instance sees this cycle, and what it shows.
    logic [63:0] cap_d [NM];
    logic        cap_v [NM];
    logic        cen   [NM];
    logic        cfl   [NM];
    logic [63:0] act_d [NM];
    logic        act_v [NM];

    always_comb begin
        for (int k = 0; k < NM; k++) begin
            cap_d[k] = inp8[32'(sel8) * 64 +: 64];
            cap_v[k] = iv8;
            cen[k]   = en8;
            cfl[k]   = fl8;
        end
        cap_d[3] = {56'd0, inp32[32'(sel32) * 8 +: 8]};
        cap_v[3] = iv32;
        cen[3]   = en32;
        cfl[3]   = fl32;
        act_d[0] = o0;         act_v[0] = ov0;
        act_d[1] = o1;         act_v[1] = ov1;
        act_d[2] = o2;         act_v[2] = ov2;
        act_d[3] = {56'd0, o3}; act_v[3] = ov3;
    end

    // Delay-line model: slot 0 receives the request accepted at this edge,
    // slot L-1 is what the output must show.
    logic        mv [NM][4];
    logic [63:0] md [NM][4];

    always @(posedge clk) begin
        for (int k = 1; k < NM; k++) begin
            if (!reset) begin
                for (int j = 0; j < 4; j++) begin
                    mv[k][j] <= 1'b0;
                    md[k][j] <= '0;
                end
            end else if (cen[k]) begin
                for (int j = 1; j < lat_of(k); j++) begin
                    md[k][j] <= md[k][j-1];
                    mv[k][j] <= mv[k][j-1] && !cfl[k];
                end
                md[k][0] <= cap_d[k];
                mv[k][0] <= cap_v[k] && !cfl[k];
            end else if (cfl[k]) begin
                for (int j = 0; j < 4; j++) mv[k][j] <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            check("u0 valid", 64'(act_v[0]), 64'(cap_v[0]));
            if (cap_v[0]) check("u0 data", act_d[0], cap_d[0]);
            for (int k = 1; k < NM; k++) begin
                check($sformatf("u%0d valid", k), 64'(act_v[k]), 64'(mv[k][lat_of(k)-1]));
                if (mv[k][lat_of(k)-1])
                    check($sformatf("u%0d data", k), act_d[k], md[k][lat_of(k)-1]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        iv8 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [63:0] got [$];
    logic [63:0] sd;
    logic        sv;

    initial begin
        reset = 1'b0;
        en8 = 1'b1; fl8 = 1'b0; iv8 = 1'b0; inp8 = '0; sel8 = '0;
        en32 = 1'b1; fl32 = 1'b0; iv32 = 1'b0; inp32 = '0; sel32 = '0;
        step();
        step();
        armed = 1'b1;

        // Reset state.
        check("reset u1 valid", 64'(ov1), 64'd0);
        check("reset u1 data",  o1, 64'd0);
        check("reset u2 valid", 64'(ov2), 64'd0);
        check("reset u2 data",  o2, 64'd0);
        check("reset u3 valid", 64'(ov3), 64'd0);
        check("reset u3 data",  64'(o3), 64'd0);
        reset = 1'b1;

        // Exhaustive sweep on the combinational instance.
        for (int i = 0; i < 8; i++) inp8[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        iv8 = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel8 = 3'(s);
            #1;
            check($sformatf("sweep sel=%0d", s), o0, 64'h1111_1111_1111_1111 * 64'(s + 1));
            if (s == 5) check("sweep sel=5 literal", o0, 64'h6666_6666_6666_6666);
            step();
        end
        drain(4);

        // Latency on u1 (L=2): single request.
        sel8 = 3'd3; iv8 = 1'b1;
        step();
        iv8 = 1'b0; sel8 = 3'd0;
        check("lat cycle1 valid", 64'(ov1), 64'd0);
        step();
        check("lat cycle2 valid", 64'(ov1), 64'd1);
        check("lat cycle2 data",  o1, 64'h4444_4444_4444_4444);
        step();
        check("lat cycle3 valid", 64'(ov1), 64'd0);
        drain(4);

        // Back-to-back with a two-cycle stall on u2 (L=3).
        sel8 = 3'd0; iv8 = 1'b1;
        step();
        sel8 = 3'd7;
        step();
        sd = o2; sv = ov2;
        en8 = 1'b0; sel8 = 3'd5;
        step();
        check("stall hold data 1",  o2, sd);
        check("stall hold valid 1", 64'(ov2), 64'(sv));
        step();
        check("stall hold data 2",  o2, sd);
        check("stall hold valid 2", 64'(ov2), 64'(sv));
        en8 = 1'b1; sel8 = 3'd2;
        step();
        iv8 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (ov2) got.push_back(o2);
            step();
        end
        check("b2b count", 64'(got.size()), 64'd3);
        if (got.size() >= 3) begin
            check("b2b first",  got[0], 64'h1111_1111_1111_1111);
            check("b2b second", got[1], 64'h8888_8888_8888_8888);
            check("b2b third",  got[2], 64'h3333_3333_3333_3333);
        end
        drain(4);

        // Flush with en=0 on u1 (L=2) while two requests are in flight.
        sel8 = 3'd1; iv8 = 1'b1;
        step();
        sel8 = 3'd6;
        step();
        fl8 = 1'b1; en8 = 1'b0; sel8 = 3'd7;
        step();
        fl8 = 1'b0; en8 = 1'b1; iv8 = 1'b0;
        check("flush next valid 1", 64'(ov1), 64'd0);
        step();
        check("flush next valid 2", 64'(ov1), 64'd0);
        sel8 = 3'd4; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        check("post-flush cycle1 valid", 64'(ov1), 64'd0);
        step();
        check("post-flush cycle2 valid", 64'(ov1), 64'd1);
        check("post-flush cycle2 data",  o1, 64'h5555_5555_5555_5555);
        drain(4);

        // Reset while two requests are in flight.
        sel8 = 3'd2; iv8 = 1'b1;
        step();
        sel8 = 3'd3;
        step();
        reset = 1'b0; iv8 = 1'b0;
        step();
        check("midreset u1 valid", 64'(ov1), 64'd0);
        check("midreset u1 data",  o1, 64'd0);
        check("midreset u2 valid", 64'(ov2), 64'd0);
        check("midreset u2 data",  o2, 64'd0);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("no stale u1", 64'(ov1), 64'd0);
            check("no stale u2", 64'(ov2), 64'd0);
        end

        // Random traffic on every instance.
        for (int c = 0; c < 1000; c++) begin
            en8  = ($urandom_range(3) != 0);
            fl8  = ($urandom_range(19) == 0);
            iv8  = 1'($urandom);
            sel8 = 3'($urandom);
            for (int w = 0; w < 16; w++) inp8[w*32 +: 32] = $urandom;
            en32  = ($urandom_range(3) != 0);
            fl32  = ($urandom_range(29) == 0);
            iv32  = 1'($urandom);
            sel32 = 5'($urandom);
            for (int w = 0; w < 8; w++) inp32[w*32 +: 32] = $urandom;
            step();
        end
        en8 = 1'b1; fl8 = 1'b0; en32 = 1'b1; fl32 = 1'b0; iv32 = 1'b0;
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
